// File: rtl/csync_generator.sv
// PAL 625-line interlaced composite sync generator with line/field timing strobes.
// All outputs are registered from the horizontal/line counters (one cycle of latency).
module csync_generator #(
    parameter int LINE_CYCLES  = 6400,
    parameter int HSYNC_CYCLES = 470,
    parameter int EQ_CYCLES    = 235,
    parameter int BROAD_CYCLES = 2730
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       enable,
    output logic       csync,
    output logic [9:0] line_num,
    output logic       field,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [12:0] HALF_W  = 13'(LINE_CYCLES / 2);
    localparam logic [12:0] LAST_H  = 13'(LINE_CYCLES - 1);
    localparam logic [12:0] HSYNC_W = 13'(HSYNC_CYCLES);
    localparam logic [12:0] EQ_W    = 13'(EQ_CYCLES);
    localparam logic [12:0] BROAD_W = 13'(BROAD_CYCLES);

    typedef enum logic [1:0] {
        PT_NONE   = 2'd0,
        PT_NORMAL = 2'd1,
        PT_EQ     = 2'd2,
        PT_BROAD  = 2'd3
    } pulse_t;

    logic [12:0] h_cnt_r;
    logic [9:0]  line_cnt_r;
    logic        second_s;
    logic [12:0] offset_s;
    pulse_t      ptype_s;
    logic        low_s;
    logic        csync_r;
    logic [9:0]  line_num_r;
    logic        field_r;
    logic        line_start_r;
    logic        frame_start_r;

    // Vertical-interval pulse pattern for one half-line of the interlaced frame.
    function automatic pulse_t pulse_type(input logic [9:0] line, input logic second);
        pulse_t pt;
        if (line <= 10'd2) begin
            pt = PT_BROAD;
        end else if (line == 10'd3) begin
            pt = second ? PT_EQ : PT_BROAD;
        end else if (line <= 10'd5) begin
            pt = PT_EQ;
        end else if (line <= 10'd310) begin
            pt = second ? PT_NONE : PT_NORMAL;
        end else if (line <= 10'd312) begin
            pt = PT_EQ;
        end else if (line == 10'd313) begin
            pt = second ? PT_BROAD : PT_EQ;
        end else if (line <= 10'd315) begin
            pt = PT_BROAD;
        end else if (line <= 10'd317) begin
            pt = PT_EQ;
        end else if (line == 10'd318) begin
            pt = second ? PT_NONE : PT_EQ;
        end else if (line <= 10'd622) begin
            pt = second ? PT_NONE : PT_NORMAL;
        end else if (line == 10'd623) begin
            pt = second ? PT_EQ : PT_NORMAL;
        end else if (line <= 10'd625) begin
            pt = PT_EQ;
        end else begin
            pt = PT_NONE;
        end
        return pt;
    endfunction

    // Decode whether the current counter position lies inside a sync pulse.
    always_comb begin
        second_s = (h_cnt_r >= HALF_W);
        if (second_s) begin
            offset_s = h_cnt_r - HALF_W;
        end else begin
            offset_s = h_cnt_r;
        end
        ptype_s = pulse_type(line_cnt_r, second_s);
        case (ptype_s)
            PT_NORMAL: low_s = (offset_s < HSYNC_W);
            PT_EQ:     low_s = (offset_s < EQ_W);
            PT_BROAD:  low_s = (offset_s < BROAD_W);
            PT_NONE:   low_s = 1'b0;
            default:   low_s = 1'b0;
        endcase
    end

    // Horizontal and line counters; disabling parks them at the frame origin.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r    <= 13'd0;
            line_cnt_r <= 10'd1;
        end else if (!enable) begin
            h_cnt_r    <= 13'd0;
            line_cnt_r <= 10'd1;
        end else if (h_cnt_r == LAST_H) begin
            h_cnt_r <= 13'd0;
            if (line_cnt_r == 10'd625) begin
                line_cnt_r <= 10'd1;
            end else begin
                line_cnt_r <= line_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r    <= h_cnt_r + 13'd1;
            line_cnt_r <= line_cnt_r;
        end
    end

    // Output registers; idle values drop any pulse in progress on the next clock.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            csync_r       <= 1'b1;
            line_num_r    <= 10'd1;
            field_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!enable) begin
            csync_r       <= 1'b1;
            line_num_r    <= 10'd1;
            field_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            csync_r       <= ~low_s;
            line_num_r    <= line_cnt_r;
            field_r       <= (line_cnt_r >= 10'd313);
            line_start_r  <= (h_cnt_r == 13'd0);
            frame_start_r <= (h_cnt_r == 13'd0) && (line_cnt_r == 10'd1);
        end
    end

    assign csync       = csync_r;
    assign line_num    = line_num_r;
    assign field       = field_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: doc/csync_generator.md
Name: csync_generator

Overview:
- Generates PAL 625-line interlaced composite sync (CSYNC) from the 100 MHz system clock. This is the transmit counterpart of the CSYNC-to-pixel-clock recovery path.
- Drives the emulator's video output sync and provides line/field timing to the overlay and pixel pipeline.
- One line is exactly 6400 clk_100mhz cycles (64 µs), which equals 864 pixels at 13.5 MHz. No fractional accumulation is needed.

Parameters:
- LINE_CYCLES, 6400: clocks per line; must be even.
- HSYNC_CYCLES, 470: line sync pulse width (4.7 µs).
- EQ_CYCLES, 235: equalizing pulse width (2.35 µs).
- BROAD_CYCLES, 2730: broad pulse low width (half-line minus 4.7 µs serration).
- Line count is fixed at 625. It is not a parameter.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  generator run; low holds the block idle
- csync  output  1  composite sync, active low
- line_num  output  10  current line, 1..625
- field  output  1  0 = field 1 (lines 1-312), 1 = field 2 (lines 313-625)
- line_start  output  1  one-cycle strobe at h_cnt = 0
- frame_start  output  1  one-cycle strobe at line 1, h_cnt = 0

Behaviour:
- Counters:
  - h_cnt runs 0..LINE_CYCLES-1 and wraps.
  - line_cnt runs 1..625. It increments on h_cnt wrap; 625 wraps to 1.
  - HALF = LINE_CYCLES/2. The first half-line is h_cnt < HALF; the second half-line is h_cnt >= HALF.
- Reset (rst_n low, async):
  - h_cnt = 0, line_cnt = 1.
  - csync = 1, field = 0, line_num = 1, line_start = 0, frame_start = 0.
- enable low (synchronous): same values as reset, applied next clock. All counters are held.
- enable rising: counting starts at h_cnt = 0, line 1.
- Half-line pulse type, indexed by line and half (first, second):
  - Lines 1, 2: BROAD, BROAD
  - Line 3: BROAD, EQ
  - Lines 4, 5: EQ, EQ
  - Lines 6-310: NORMAL, NONE
  - Lines 311, 312: EQ, EQ
  - Line 313: EQ, BROAD
  - Lines 314, 315: BROAD, BROAD
  - Lines 316, 317: EQ, EQ
  - Line 318: EQ, NONE
  - Lines 319-622: NORMAL, NONE
  - Line 623: NORMAL, EQ
  - Lines 624, 625: EQ, EQ
- Pulse low condition, with p = offset within the current half-line (0..HALF-1):
  - NORMAL: p < HSYNC_CYCLES
  - EQ: p < EQ_CYCLES
  - BROAD: p < BROAD_CYCLES
  - NONE: never low
- Latency and alignment:
  - All outputs are registered from the current counter state, so every output lags the counters by 1 cycle.
  - csync(t+1) = NOT low(h_cnt(t), line_cnt(t)).
  - line_start(t+1) = (h_cnt(t) == 0).
  - frame_start(t+1) = (h_cnt(t) == 0 AND line_cnt(t) == 1).
  - line_num and field update on the same cycle as line_start.
  - field = 1 when line_cnt >= 313.
- Counter widths: h_cnt is 13 bits; line_cnt is 10 bits.
- Period: a frame is exactly 625 × 6400 = 4,000,000 cycles, and the sequence repeats exactly.
- Reset or enable low during a pulse: csync returns high immediately (async for reset, next clock for enable). No partial pulse resumes afterwards.
- Parameter legality: BROAD_CYCLES, HSYNC_CYCLES and EQ_CYCLES must each be < HALF. Out-of-range values are illegal; behaviour is undefined and need not be checked in RTL.

Test Plan:
- Release rst_n with enable = 1 → frame_start pulses on cycle 1. csync is low for cycles 1-2730, high for 2731-3200, low for 3201-5930, high for 5931-6400.
- Run to line 6 → line_num = 6. csync is low for exactly 470 cycles starting 1 cycle after h_cnt = 0, then high for 5930 cycles. line_start recurs every 6400 cycles.
- Lines 311-318 → count pulses and widths:
  - 4 EQ (235) pulses on lines 311-312.
  - Line 313: EQ at the start, broad at mid-line; field goes to 1 with line_num = 313.
  - Lines 314-315: 4 broad pulses.
  - Lines 316-317: EQ pulses.
  - Line 318: a single EQ with no mid-line pulse.
- Lines 623-625 wrapping to 1 → line 623 has a 470 hsync plus a mid-line EQ. Line 625 is followed by line_num = 1, field = 0, and frame_start. The next frame_start comes exactly 4,000,000 cycles after the previous one.
- Deassert enable mid-broad-pulse (line 2, h_cnt = 1000) → csync = 1 on the next cycle and line_num = 1. Re-enabling reproduces the first scenario's waveform from cycle 1.
- Assert rst_n = 0 asynchronously mid-hsync on line 100 → csync = 1 immediately with no clock. After release, the first scenario's sequence repeats.
